// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-request APB master sequencer for the AHB-APB bridge.
// Decodes the slave from addr[31:26], runs IDLE->SETUP->ENABLE, returns rdata/err.
// Optional feature macro APB_WAIT_EN: honour pready with a 4-bit wait counter and
// TIMEOUT abort. Without it, pready is ignored and ENABLE lasts exactly one cycle.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              pwrite,
  output logic [2:0]        psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE} state_t;

  state_t            state, state_nxt;
  logic              req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              pwrite_nxt, penable_nxt;
  logic [2:0]        psel_nxt, hit;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              fin, tmo;

`ifdef APB_WAIT_EN
  logic [3:0] wait_cnt, wait_cnt_nxt, wait_inc;
`else
  logic unused_pready;
  assign unused_pready = pready;
`endif

  // One-hot slave select from the 64 MB region index in addr[31:26]
  function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
    decode = 3'b000;
    if (a[31:26] == SLV0_BASE[31:26]) decode = 3'b001;
    else if (a[31:26] == SLV1_BASE[31:26]) decode = 3'b010;
    else if (a[31:26] == SLV2_BASE[31:26]) decode = 3'b100;
  endfunction

  // State and registered outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pwrite    <= 1'b0;
      psel      <= 3'b000;
      penable   <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
`ifdef APB_WAIT_EN
      wait_cnt  <= 4'd0;
`endif
    end else begin
      state     <= state_nxt;
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      pwrite    <= pwrite_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
`ifdef APB_WAIT_EN
      wait_cnt  <= wait_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    req_ready_nxt = 1'b0;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = '0;
    rsp_err_nxt   = 1'b0;
    pwrite_nxt    = pwrite;
    psel_nxt      = psel;
    penable_nxt   = penable;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    hit           = decode(req_addr);
    fin           = 1'b0;
    tmo           = 1'b0;
`ifdef APB_WAIT_EN
    wait_cnt_nxt  = wait_cnt;
    wait_inc      = wait_cnt + 4'd1;
`endif

    case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        psel_nxt      = 3'b000;
        penable_nxt   = 1'b0;
        if (req_valid && req_ready) begin
          if (|hit) begin
            state_nxt     = SETUP;
            req_ready_nxt = 1'b0;
            psel_nxt      = hit;
            pwrite_nxt    = req_write;
            paddr_nxt     = req_addr;
            pwdata_nxt    = req_wdata;
`ifdef APB_WAIT_EN
            wait_cnt_nxt  = 4'd0;
`endif
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nxt   = ENABLE;
        penable_nxt = 1'b1;
      end
      ENABLE: begin
`ifdef APB_WAIT_EN
        if (pready) fin = 1'b1;
        else if (wait_inc == 4'(TIMEOUT)) tmo = 1'b1;
        else wait_cnt_nxt = wait_inc;
`else
        fin = 1'b1;
`endif
        if (fin || tmo) begin
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
          psel_nxt      = 3'b000;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = tmo;
          rsp_rdata_nxt = (fin && !pwrite) ? prdata : '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
